cordic_quadrant_wrap: RTL

Full-circle front/back end for the first-quadrant `cordic` engine. It accepts a full-circle angle on a valid/ready stream and strips the quadrant bits. It drives the engine's `start`/`angle` inputs, then waits for `done` and captures `out_x`/`out_y`. Finally it folds the quadrant back in to present signed cosine/sine on an output valid/ready stream. It sits directly upstream and downstream of `cordic` and is the only block that talks to the engine's handshake pins.

---
 rtl/cordic_quadrant_wrap.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cordic_quadrant_wrap.sv
// ---------------------------------------------------------------------------
// cordic_quadrant_wrap
//
// Purpose:
//   Full-circle wrapper around the first-quadrant cordic engine. An angle
//   arrives on a valid/ready stream. The two quadrant bits are stripped and
//   stored, and the in-quadrant offset is handed to the engine. When the
//   engine finishes, its unsigned x/y results are folded back into the
//   correct quadrant. The result is then presented as signed cos/sin on an
//   output valid/ready stream.
//
// Parameters:
//   BIT_WIDTH     engine data/angle width (must match the attached engine)
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous active-high reset
//   in_valid      input angle offered
//   in_ready      angle accepted this cycle
//   in_angle      {quadrant[1:0], offset[BIT_WIDTH-1:0]}
//   out_valid     result held on out_cos/out_sin
//   out_ready     consumer takes the result
//   out_cos       signed cos(theta), BIT_WIDTH+1 bits
//   out_sin       signed sin(theta), BIT_WIDTH+1 bits
//   cordic_start  engine start request, one cycle per job
//   cordic_angle  registered offset driven to the engine
//   cordic_ready  engine can take a request
//   cordic_done   engine result valid
//   cordic_x      engine x result, unsigned
//   cordic_y      engine y result, unsigned
// ---------------------------------------------------------------------------
module cordic_quadrant_wrap #(
    parameter int BIT_WIDTH = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH+1:0] in_angle,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH:0]   out_cos,
    output logic [BIT_WIDTH:0]   out_sin,
    output logic                 cordic_start,
    output logic [BIT_WIDTH-1:0] cordic_angle,
    input  logic                 cordic_ready,
    input  logic                 cordic_done,
    input  logic [BIT_WIDTH-1:0] cordic_x,
    input  logic [BIT_WIDTH-1:0] cordic_y
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ACK,
        WAIT,
        HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [1:0]             r_quadrant;
    logic [BIT_WIDTH-1:0]   r_angle;
    logic [BIT_WIDTH:0]     r_cos;
    logic [BIT_WIDTH:0]     r_sin;
    logic                   r_outValid;
    logic                   r_resetDone;

    logic                   w_inReady;
    logic                   w_start;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_transfer;
    logic signed [BIT_WIDTH:0] w_xExt;
    logic signed [BIT_WIDTH:0] w_yExt;
    logic signed [BIT_WIDTH:0] w_foldCos;
    logic signed [BIT_WIDTH:0] w_foldSin;

    // Next-state and handshake decode. In IDLE the input is gated by
    // r_resetDone so in_ready stays low while reset is held and rises only
    // after the first clock following release. In HOLD a new angle can only
    // be taken together with the outgoing result, so in_ready mirrors
    // out_ready there. Any done seen in START or ACK is ignored; ACK waits for
    // done to drop so a stale done from the last job cannot be mistaken for
    // the new result.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = r_resetDone;
                if (in_valid && r_resetDone) begin
                    w_nextState = START;
                end
            end
            START: begin
                w_start = cordic_ready;
                if (cordic_ready) begin
                    w_nextState = ACK;
                end
            end
            ACK: begin
                if (!cordic_done) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (cordic_done) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                w_inReady = out_ready;
                if (out_ready) begin
                    w_nextState = in_valid ? START : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_accept   = in_valid && w_inReady;
    assign w_capture  = (r_state == WAIT) && cordic_done;
    assign w_transfer = r_outValid && out_ready;

    // Quadrant fold. The engine results are non-negative and below
    // 2^BIT_WIDTH, so after zero-extension by one bit the negation is exact
    // and can never overflow.
    assign w_xExt = {1'b0, cordic_x};
    assign w_yExt = {1'b0, cordic_y};

    always_comb begin
        w_foldCos = w_xExt;
        w_foldSin = w_yExt;
        case (r_quadrant)
            2'd0: begin
                w_foldCos = w_xExt;
                w_foldSin = w_yExt;
            end
            2'd1: begin
                w_foldCos = -w_yExt;
                w_foldSin = w_xExt;
            end
            2'd2: begin
                w_foldCos = -w_xExt;
                w_foldSin = -w_yExt;
            end
            default: begin
                w_foldCos = w_yExt;
                w_foldSin = -w_xExt;
            end
        endcase
    end

    // State and datapath registers. The angle and quadrant registers change
    // only when an input is accepted, so the engine sees a stable angle for
    // the whole job. A transfer in HOLD always clears out_valid. A
    // back-to-back accept in the same cycle simply starts the next job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_quadrant  <= 2'd0;
            r_angle     <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_outValid  <= 1'b0;
            r_resetDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_resetDone <= 1'b1;
            if (w_accept) begin
                r_quadrant <= in_angle[BIT_WIDTH+1:BIT_WIDTH];
                r_angle    <= in_angle[BIT_WIDTH-1:0];
            end
            if (w_capture) begin
                r_cos      <= w_foldCos;
                r_sin      <= w_foldSin;
                r_outValid <= 1'b1;
            end else if (w_transfer) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign in_ready     = w_inReady;
    assign out_valid    = r_outValid;
    assign out_cos      = r_cos;
    assign out_sin      = r_sin;
    assign cordic_start = w_start;
    assign cordic_angle = r_angle;

endmodule
